mux_scan_n: RTL and testbench
=============================

Name: mux_scan_n

Overview:
- Parametrised N-channel, W-bit registered multiplexer.
- Two modes: manual select, or auto-scan that walks enabled channels round-robin with a programmable dwell per channel.
- Outputs registered sample, channel tag, valid and start-of-frame strobe.
- Next generation of the team's fixed 13:1 single-bit mux; feeds serial/telemetry paths that time-share one output among many sources.

Parameters:
- N_CH, 13, number of input channels (2..64).
- W, 1, bits per channel.
- DWELL, 1, clock cycles spent on each channel in auto mode (1..256).
- SW, $clog2(N_CH), localparam, select width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- d  in  N_CH*W  flat input bus; channel i is d[i*W +: W].
- mode  in  1  0 = manual, 1 = auto-scan.
- sel_in  in  SW  manual channel select.
- en_mask  in  N_CH  per-channel enable; bit i = 1 means channel i is eligible.
- out  out  W  registered selected data.
- out_valid  out  1  out holds data from an enabled, legal channel.
- cur_sel  out  SW  channel index that out was sampled from.
- sof  out  1  one-cycle pulse when the auto scan wraps to a new frame.
- sel_err  out  1  manual sel_in >= N_CH this cycle (registered).

Behaviour:
- Reset (rst_n = 0, asynchronous): out = 0, out_valid = 0, cur_sel = 0, sof = 0, sel_err = 0, dwell counter = 0. First update is on the first rising clk after release.
- Coherence: sel_nxt is computed combinationally. On each edge, cur_sel <= sel_nxt and out <= d[sel_nxt], sampled at that same edge. out and cur_sel always describe the same channel. Latency from input to out is 1 cycle.
- Manual mode (mode = 0):
  - sel_nxt = sel_in.
  - If sel_in >= N_CH: out <= 0, out_valid <= 0, sel_err <= 1, cur_sel <= sel_in.
  - Otherwise: sel_err <= 0 and out_valid <= en_mask[sel_in]; out <= 0 when that channel is disabled.
  - sof = 0 throughout.
  - The dwell counter is held at 0.
- Auto mode (mode = 1):
  - The dwell counter runs 0..DWELL-1. At DWELL-1 it advances: sel_nxt = next enabled index after cur_sel, searching cur_sel+1 upward and wrapping modulo N_CH. The counter then returns to 0.
  - Between advances, sel_nxt = cur_sel and out tracks live d of that channel every cycle.
  - sof <= 1 on an advance edge where the new index <= the old index (wrap). A single enabled channel therefore gives sof on every advance.
  - en_mask all zero: cur_sel holds, out <= 0, out_valid <= 0, sof <= 0, counter keeps running.
  - Current channel disabled mid-dwell: out_valid <= 0 and out <= 0 immediately; the move to the next enabled channel happens at the normal advance.
  - If cur_sel >= N_CH on entry to auto (a leftover illegal manual select), the next advance searches from index 0.
  - sel_err <= 0.
- Mode switches:
  - Manual to auto: the scan starts from the current cur_sel and the dwell counter is cleared to 0.
  - Auto to manual: sel_in takes effect at the next edge; sof is forced to 0.
- DWELL = 1: advance on every cycle, so all enabled channels are visited in consecutive cycles.

Decomposition:
- Package mux_scan_pkg: mode encodings (MODE_MANUAL = 1'b0, MODE_AUTO = 1'b1) and a function returning the SW for a given N_CH.
- Sub-module mux_next_ch: purely combinational. Takes cur, en_mask and N_CH; returns the next enabled index, a wrap flag and a none_enabled flag, using a rotate-and-priority-encode search.
- The top level holds the dwell counter, the select register and the output registers.

Test Plan (N_CH = 13, W = 1, d[i] = ~i[0], so d0 = 1, d1 = 0, ...):
- Reset mid-scan: assert rst_n = 0 at cycle 7 of auto -> out, out_valid, cur_sel, sof and sel_err all 0 immediately, before any clock edge.
- Manual sweep with en_mask = all ones: sel_in = 0..12, one value per cycle -> out = 1,0,1,... one cycle later, out_valid = 1. sel_in = 13 -> sel_err = 1, out_valid = 0, out = 0.
- Auto scan, DWELL = 2, all enabled: cur_sel steps 0,0,1,1,...,12,12,0 -> sof pulses exactly on the 12→0 edge, once every 26 cycles.
- Auto with en_mask = 13'h0005 (channels 0 and 2): cur_sel alternates 0, 2, 0 -> sof on each 2→0 edge, out always 1. en_mask = 0 -> out_valid = 0 and cur_sel frozen.
- Disable the current channel mid-dwell (DWELL = 4, cur_sel = 3, clear bit 3) -> out_valid drops the next cycle; at the advance cur_sel moves to 4.
- Mode switches: manual sel_in = 5, then mode = 1 -> scan continues 5, 6, ... with the counter cleared. mode = 0 with sel_in = 9 -> cur_sel = 9 the next cycle, sof = 0.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared definitions for the N-channel scanning multiplexer.
package mux_scan_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_AUTO   = 1'b1;

  // Select width for a given channel count (never narrower than one bit).
  function automatic int unsigned sel_width(input int unsigned n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/mux_next_ch.sv
// Finds the next enabled channel after cur, wrapping modulo N_CH.
module mux_next_ch
  import mux_scan_pkg::*;
#(
  parameter  int unsigned N_CH = 13,
  localparam int unsigned SW   = sel_width(N_CH)
) (
  input  logic [SW-1:0]   cur,
  input  logic [N_CH-1:0] en_mask,
  output logic [SW-1:0]   nxt_c,
  output logic            wrap_c,
  output logic            none_c
);

  logic [SW-1:0]   start;
  logic [SW-1:0]   off;
  logic [N_CH-1:0] rot;
  logic            found;
  int unsigned     sum;

  // Rotate the mask so the search origin sits at bit 0, then priority-encode.
  always_comb begin
    start = '0;
    if (32'(cur) < N_CH - 1) begin
      start = cur + SW'(1);
    end
    // An illegal cur (>= N_CH) lands here with start = 0: search from channel 0.
    rot   = N_CH'({en_mask, en_mask} >> start);
    found = 1'b0;
    off   = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = SW'(i);
      end
    end
    sum = 32'(start) + 32'(off);
    if (sum >= N_CH) begin
      sum = sum - N_CH;
    end
    nxt_c  = SW'(sum);
    wrap_c = (32'(nxt_c) <= 32'(cur));
    none_c = ~|en_mask;
  end

endmodule

// File: rtl/mux_scan_n.sv
// N-channel registered mux with manual select or round-robin auto scan.
module mux_scan_n
  import mux_scan_pkg::*;
#(
  parameter  int unsigned N_CH  = 13,
  parameter  int unsigned W     = 1,
  parameter  int unsigned DWELL = 1,
  localparam int unsigned SW    = sel_width(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] d,
  input  logic              mode,
  input  logic [SW-1:0]     sel_in,
  input  logic [N_CH-1:0]   en_mask,
  output logic [W-1:0]      out,
  output logic              out_valid,
  output logic [SW-1:0]     cur_sel,
  output logic              sof,
  output logic              sel_err
);

  localparam int unsigned   CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [SW-1:0] sel_nxt;
  logic [SW-1:0] scan_nxt;
  logic          scan_wrap;
  logic          scan_none;
  logic          adv;
  logic          sof_nxt;
  logic          err_nxt;
  logic          ch_en;
  logic [W-1:0]  ch_data;
  logic          valid_nxt;
  logic [W-1:0]  out_nxt;

  mux_next_ch #(
    .N_CH (N_CH)
  ) u_next_ch (
    .cur     (cur_sel),
    .en_mask (en_mask),
    .nxt_c   (scan_nxt),
    .wrap_c  (scan_wrap),
    .none_c  (scan_none)
  );

  // Select / dwell next state: manual follows sel_in, auto advances at dwell end.
  always_comb begin
    cnt_nxt = '0;
    sel_nxt = cur_sel;
    adv     = 1'b0;
    sof_nxt = 1'b0;
    err_nxt = 1'b0;
    if (mode == MODE_AUTO) begin
      adv     = (cnt == CNT_LAST);
      cnt_nxt = adv ? '0 : cnt + CW'(1);
      if (adv && !scan_none) begin
        sel_nxt = scan_nxt;
        sof_nxt = scan_wrap;
      end
    end else begin
      // Counter held at 0 here, so entering auto always starts a fresh dwell.
      sel_nxt = sel_in;
      err_nxt = (32'(sel_in) >= N_CH);
    end
  end

  // Data path: pick the channel named by sel_nxt so out and cur_sel stay coherent.
  always_comb begin
    ch_en   = 1'b0;
    ch_data = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (sel_nxt == SW'(i)) begin
        ch_en   = en_mask[i];
        ch_data = d[i*W +: W];
      end
    end
    valid_nxt = ch_en;
    out_nxt   = ch_en ? ch_data : '0;
  end

  // Output and state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      cur_sel   <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      sof       <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      cur_sel   <= sel_nxt;
      out       <= out_nxt;
      out_valid <= valid_nxt;
      sof       <= sof_nxt;
      sel_err   <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mux_scan_n.sv
// Directed bench for mux_scan_n: three instances with DWELL = 1, 2, 4 share inputs.
module tb_mux_scan_n;

  logic        clk;
  logic        rst_n;
  logic [12:0] d;
  logic        mode;
  logic [3:0]  sel_in;
  logic [12:0] en_mask;

  logic       out_d1, val_d1, sof_d1, err_d1;
  logic [3:0] cur_d1;
  logic       out_d2, val_d2, sof_d2, err_d2;
  logic [3:0] cur_d2;
  logic       out_d4, val_d4, sof_d4, err_d4;
  logic [3:0] cur_d4;

  int checks   = 0;
  int failures = 0;

  mux_scan_n #(.N_CH(13), .W(1), .DWELL(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .d(d), .mode(mode), .sel_in(sel_in), .en_mask(en_mask),
    .out(out_d1), .out_valid(val_d1), .cur_sel(cur_d1), .sof(sof_d1), .sel_err(err_d1)
  );
  mux_scan_n #(.N_CH(13), .W(1), .DWELL(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .d(d), .mode(mode), .sel_in(sel_in), .en_mask(en_mask),
    .out(out_d2), .out_valid(val_d2), .cur_sel(cur_d2), .sof(sof_d2), .sel_err(err_d2)
  );
  mux_scan_n #(.N_CH(13), .W(1), .DWELL(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .d(d), .mode(mode), .sel_in(sel_in), .en_mask(en_mask),
    .out(out_d4), .out_valid(val_d4), .cur_sel(cur_d4), .sof(sof_d4), .sel_err(err_d4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n   = 1'b0;
    mode    = 1'b0;
    sel_in  = 4'd0;
    en_mask = 13'h1FFF;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; mode = 1'b0; sel_in = 4'd0; en_mask = 13'h1FFF;
    #2;
    checks++; if (out_d2 !== 1'b0) begin failures++; $display("FAIL rst_out got=%0d exp=0", out_d2); end
    checks++; if (val_d2 !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0d exp=0", val_d2); end
    checks++; if (cur_d2 !== 4'd0) begin failures++; $display("FAIL rst_cur got=%0d exp=0", cur_d2); end
    // Run auto for 7 cycles, then reset asynchronously between edges.
    do_reset();
    mode = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    checks++; if (cur_d2 !== 4'd3) begin failures++; $display("FAIL prerst_cur got=%0d exp=3", cur_d2); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_d2 !== 1'b0) begin failures++; $display("FAIL midrst_out got=%0d exp=0", out_d2); end
    checks++; if (val_d2 !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%0d exp=0", val_d2); end
    checks++; if (cur_d2 !== 4'd0) begin failures++; $display("FAIL midrst_cur got=%0d exp=0", cur_d2); end
    checks++; if (sof_d2 !== 1'b0) begin failures++; $display("FAIL midrst_sof got=%0d exp=0", sof_d2); end
    checks++; if (err_d2 !== 1'b0) begin failures++; $display("FAIL midrst_err got=%0d exp=0", err_d2); end
    checks++; if (cur_d1 !== 4'd0) begin failures++; $display("FAIL midrst_cur_d1 got=%0d exp=0", cur_d1); end
    checks++; if (cur_d4 !== 4'd0) begin failures++; $display("FAIL midrst_cur_d4 got=%0d exp=0", cur_d4); end
  endtask

  task automatic test_manual_sweep;
    logic e_out;
    do_reset();
    for (int s = 0; s < 13; s++) begin
      sel_in = 4'(s);
      tick();
      e_out = (s % 2 == 0);
      checks++; if (out_d2 !== e_out) begin failures++; $display("FAIL man_out s=%0d got=%0d exp=%0d", s, out_d2, e_out); end
      checks++; if (val_d2 !== 1'b1) begin failures++; $display("FAIL man_valid s=%0d got=%0d exp=1", s, val_d2); end
      checks++; if (cur_d2 !== 4'(s)) begin failures++; $display("FAIL man_cur s=%0d got=%0d exp=%0d", s, cur_d2, s); end
      checks++; if (err_d2 !== 1'b0) begin failures++; $display("FAIL man_err s=%0d got=%0d exp=0", s, err_d2); end
      checks++; if (sof_d2 !== 1'b0) begin failures++; $display("FAIL man_sof s=%0d got=%0d exp=0", s, sof_d2); end
    end
    sel_in = 4'd13;
    tick();
    checks++; if (err_d2 !== 1'b1) begin failures++; $display("FAIL man13_err got=%0d exp=1", err_d2); end
    checks++; if (val_d2 !== 1'b0) begin failures++; $display("FAIL man13_valid got=%0d exp=0", val_d2); end
    checks++; if (out_d2 !== 1'b0) begin failures++; $display("FAIL man13_out got=%0d exp=0", out_d2); end
    checks++; if (cur_d2 !== 4'd13) begin failures++; $display("FAIL man13_cur got=%0d exp=13", cur_d2); end
    // Disabled legal channel: no valid, output forced low.
    en_mask = 13'h1FEF;
    sel_in  = 4'd4;
    tick();
    checks++; if (val_d2 !== 1'b0) begin failures++; $display("FAIL mandis_valid got=%0d exp=0", val_d2); end
    checks++; if (out_d2 !== 1'b0) begin failures++; $display("FAIL mandis_out got=%0d exp=0", out_d2); end
    checks++; if (err_d2 !== 1'b0) begin failures++; $display("FAIL mandis_err got=%0d exp=0", err_d2); end
  endtask

  task automatic test_auto_scan;
    logic [3:0] e_cur2, e_cur1, e_cur4;
    logic       e_sof2, e_sof1, e_sof4;
    do_reset();
    mode = 1'b1;
    for (int k = 1; k <= 52; k++) begin
      tick();
      e_cur2 = 4'((k / 2) % 13); e_sof2 = (k % 26 == 0);
      e_cur1 = 4'(k % 13);       e_sof1 = (k % 13 == 0);
      e_cur4 = 4'((k / 4) % 13); e_sof4 = (k % 52 == 0);
      checks++; if (cur_d2 !== e_cur2) begin failures++; $display("FAIL scan2_cur k=%0d got=%0d exp=%0d", k, cur_d2, e_cur2); end
      checks++; if (sof_d2 !== e_sof2) begin failures++; $display("FAIL scan2_sof k=%0d got=%0d exp=%0d", k, sof_d2, e_sof2); end
      checks++; if (out_d2 !== ~e_cur2[0]) begin failures++; $display("FAIL scan2_out k=%0d got=%0d exp=%0d", k, out_d2, ~e_cur2[0]); end
      checks++; if (val_d2 !== 1'b1) begin failures++; $display("FAIL scan2_valid k=%0d got=%0d exp=1", k, val_d2); end
      checks++; if (cur_d1 !== e_cur1) begin failures++; $display("FAIL scan1_cur k=%0d got=%0d exp=%0d", k, cur_d1, e_cur1); end
      checks++; if (sof_d1 !== e_sof1) begin failures++; $display("FAIL scan1_sof k=%0d got=%0d exp=%0d", k, sof_d1, e_sof1); end
      checks++; if (out_d1 !== ~e_cur1[0]) begin failures++; $display("FAIL scan1_out k=%0d got=%0d exp=%0d", k, out_d1, ~e_cur1[0]); end
      checks++; if (cur_d4 !== e_cur4) begin failures++; $display("FAIL scan4_cur k=%0d got=%0d exp=%0d", k, cur_d4, e_cur4); end
      checks++; if (sof_d4 !== e_sof4) begin failures++; $display("FAIL scan4_sof k=%0d got=%0d exp=%0d", k, sof_d4, e_sof4); end
    end
  endtask

  task automatic test_auto_sparse;
    logic [3:0] e_cur2, e_cur1;
    logic       e_sof2, e_sof1;
    do_reset();
    en_mask = 13'h0005;
    mode    = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      e_cur2 = ((k / 2) % 2 == 1) ? 4'd2 : 4'd0; e_sof2 = (k % 4 == 0);
      e_cur1 = (k % 2 == 1) ? 4'd2 : 4'd0;       e_sof1 = (k % 2 == 0);
      checks++; if (cur_d2 !== e_cur2) begin failures++; $display("FAIL sparse2_cur k=%0d got=%0d exp=%0d", k, cur_d2, e_cur2); end
      checks++; if (sof_d2 !== e_sof2) begin failures++; $display("FAIL sparse2_sof k=%0d got=%0d exp=%0d", k, sof_d2, e_sof2); end
      checks++; if (out_d2 !== 1'b1) begin failures++; $display("FAIL sparse2_out k=%0d got=%0d exp=1", k, out_d2); end
      checks++; if (cur_d1 !== e_cur1) begin failures++; $display("FAIL sparse1_cur k=%0d got=%0d exp=%0d", k, cur_d1, e_cur1); end
      checks++; if (sof_d1 !== e_sof1) begin failures++; $display("FAIL sparse1_sof k=%0d got=%0d exp=%0d", k, sof_d1, e_sof1); end
    end
    en_mask = 13'h0000;
    for (int k = 1; k <= 6; k++) begin
      tick();
      checks++; if (cur_d2 !== 4'd0) begin failures++; $display("FAIL none_cur k=%0d got=%0d exp=0", k, cur_d2); end
      checks++; if (val_d2 !== 1'b0) begin failures++; $display("FAIL none_valid k=%0d got=%0d exp=0", k, val_d2); end
      checks++; if (out_d2 !== 1'b0) begin failures++; $display("FAIL none_out k=%0d got=%0d exp=0", k, out_d2); end
      checks++; if (sof_d2 !== 1'b0) begin failures++; $display("FAIL none_sof k=%0d got=%0d exp=0", k, sof_d2); end
      checks++; if (sof_d1 !== 1'b0) begin failures++; $display("FAIL none_sof_d1 k=%0d got=%0d exp=0", k, sof_d1); end
    end
  endtask

  task automatic test_disable_mid_dwell;
    do_reset();
    sel_in = 4'd3;
    tick();
    checks++; if (cur_d4 !== 4'd3) begin failures++; $display("FAIL dis_start_cur got=%0d exp=3", cur_d4); end
    mode = 1'b1;
    tick();
    checks++; if (val_d4 !== 1'b1) begin failures++; $display("FAIL dis_e1_valid got=%0d exp=1", val_d4); end
    checks++; if (cur_d4 !== 4'd3) begin failures++; $display("FAIL dis_e1_cur got=%0d exp=3", cur_d4); end
    en_mask = 13'h1FF7;
    tick();
    checks++; if (val_d4 !== 1'b0) begin failures++; $display("FAIL dis_e2_valid got=%0d exp=0", val_d4); end
    checks++; if (out_d4 !== 1'b0) begin failures++; $display("FAIL dis_e2_out got=%0d exp=0", out_d4); end
    checks++; if (cur_d4 !== 4'd3) begin failures++; $display("FAIL dis_e2_cur got=%0d exp=3", cur_d4); end
    tick();
    checks++; if (cur_d4 !== 4'd3) begin failures++; $display("FAIL dis_e3_cur got=%0d exp=3", cur_d4); end
    checks++; if (val_d4 !== 1'b0) begin failures++; $display("FAIL dis_e3_valid got=%0d exp=0", val_d4); end
    tick();
    checks++; if (cur_d4 !== 4'd4) begin failures++; $display("FAIL dis_adv_cur got=%0d exp=4", cur_d4); end
    checks++; if (val_d4 !== 1'b1) begin failures++; $display("FAIL dis_adv_valid got=%0d exp=1", val_d4); end
    checks++; if (out_d4 !== 1'b1) begin failures++; $display("FAIL dis_adv_out got=%0d exp=1", out_d4); end
    checks++; if (sof_d4 !== 1'b0) begin failures++; $display("FAIL dis_adv_sof got=%0d exp=0", sof_d4); end
  endtask

  task automatic test_mode_switch;
    logic [3:0] e_cur [4];
    logic       e_out [4];
    e_cur = '{4'd5, 4'd6, 4'd6, 4'd7};
    e_out = '{1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    sel_in = 4'd5;
    tick();
    checks++; if (cur_d2 !== 4'd5) begin failures++; $display("FAIL sw_man_cur got=%0d exp=5", cur_d2); end
    mode = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (cur_d2 !== e_cur[k]) begin failures++; $display("FAIL sw_auto_cur k=%0d got=%0d exp=%0d", k, cur_d2, e_cur[k]); end
      checks++; if (out_d2 !== e_out[k]) begin failures++; $display("FAIL sw_auto_out k=%0d got=%0d exp=%0d", k, out_d2, e_out[k]); end
    end
    mode   = 1'b0;
    sel_in = 4'd9;
    tick();
    checks++; if (cur_d2 !== 4'd9) begin failures++; $display("FAIL sw_back_cur got=%0d exp=9", cur_d2); end
    checks++; if (sof_d2 !== 1'b0) begin failures++; $display("FAIL sw_back_sof got=%0d exp=0", sof_d2); end
    checks++; if (val_d2 !== 1'b1) begin failures++; $display("FAIL sw_back_valid got=%0d exp=1", val_d2); end
    checks++; if (cur_d1 !== 4'd9) begin failures++; $display("FAIL sw_back_cur_d1 got=%0d exp=9", cur_d1); end
    // Leftover illegal manual select: the first auto advance searches from channel 0.
    sel_in = 4'd14;
    tick();
    checks++; if (cur_d2 !== 4'd14) begin failures++; $display("FAIL ill_cur got=%0d exp=14", cur_d2); end
    checks++; if (err_d2 !== 1'b1) begin failures++; $display("FAIL ill_err got=%0d exp=1", err_d2); end
    mode = 1'b1;
    tick();
    checks++; if (cur_d2 !== 4'd14) begin failures++; $display("FAIL ill_hold_cur got=%0d exp=14", cur_d2); end
    checks++; if (err_d2 !== 1'b0) begin failures++; $display("FAIL ill_hold_err got=%0d exp=0", err_d2); end
    checks++; if (val_d2 !== 1'b0) begin failures++; $display("FAIL ill_hold_valid got=%0d exp=0", val_d2); end
    checks++; if (cur_d1 !== 4'd0) begin failures++; $display("FAIL ill_d1_cur got=%0d exp=0", cur_d1); end
    checks++; if (sof_d1 !== 1'b1) begin failures++; $display("FAIL ill_d1_sof got=%0d exp=1", sof_d1); end
    tick();
    checks++; if (cur_d2 !== 4'd0) begin failures++; $display("FAIL ill_adv_cur got=%0d exp=0", cur_d2); end
    checks++; if (sof_d2 !== 1'b1) begin failures++; $display("FAIL ill_adv_sof got=%0d exp=1", sof_d2); end
    checks++; if (out_d2 !== 1'b1) begin failures++; $display("FAIL ill_adv_out got=%0d exp=1", out_d2); end
  endtask

  initial begin
    d       = 13'h1555;
    rst_n   = 1'b0;
    mode    = 1'b0;
    sel_in  = 4'd0;
    en_mask = 13'h1FFF;
    test_reset();
    test_manual_sweep();
    test_auto_scan();
    test_auto_sparse();
    test_disable_mid_dwell();
    test_mode_switch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
